// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 8N1 UART receiver with oversampled bit timing and valid/ready byte delivery
module uart_rx_oversample #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0] DIV_END = DW'(DIV - 1);
  localparam logic [SW-1:0] HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
  state_t state, state_n;
  logic s1, s2, hist;
  logic [1:0] primed;
  logic [DW-1:0] div_cnt;
  logic [SW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic tick, start, half, full, deliver, stop_bad;
  assign tick = div_cnt == DIV_END;
  assign start = state == IDLE && hist && !s2;
  assign half = state == START && tick && cnt == HALF;
  assign full = (state == DATA || state == STOP) && tick && cnt == LAST;
  assign deliver = state == STOP && full && s2;
  assign stop_bad = state == STOP && full && !s2;
  assign busy = state != IDLE;
  // next-state: start detect, start-bit centre check, 8 data bits, stop check, wait for line high
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? START : IDLE;
      START:   state_n = half ? (s2 ? IDLE : DATA) : START;
      DATA:    state_n = full && bit_idx == 3'd7 ? STOP : DATA;
      STOP:    state_n = full ? (s2 ? IDLE : WAIT_HI) : STOP;
      WAIT_HI: state_n = s2 ? IDLE : WAIT_HI;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // synchroniser, baud timebase, bit sampling and output handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      hist <= 1'b0;
      primed <= 2'b00;
      div_cnt <= '0;
      cnt <= '0;
      bit_idx <= 3'd0;
      shift <= 8'h00;
      rx_data <= 8'h00;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      s1 <= rx_in;
      s2 <= s1;
      primed <= {primed[0], 1'b1};
      // history only trusts the synchroniser once its reset value has flushed out,
      // so a line already low at reset release never looks like a falling edge
      hist <= s2 & primed[1];
      div_cnt <= start || tick ? '0 : div_cnt + 1'b1;
      cnt <= state == IDLE || state == WAIT_HI || half || full ? '0 : cnt + SW'(tick);
      if (half) bit_idx <= 3'd0;
      else if (state == DATA && full) begin
        bit_idx <= bit_idx + 3'd1;
        shift <= {s2, shift[7:1]};
      end
      frame_err <= stop_bad;
      overrun <= deliver && rx_valid && !rx_ready;
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data <= shift;
        rx_valid <= 1'b1;
      end else if (rx_ready) rx_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample: directed and randomized frames checked against a frame-level receiver model
module tb_uart_rx_oversample;
  logic clk = 1'b0, rst_n = 1'b0, rx_in = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, busy;
  int n_pass = 0, n_chk = 0;
  int n_ferr = 0, n_ovr = 0, n_busy = 0, n_vrise = 0, n_vhi = 0, n_both = 0;
  int b_ferr, b_ovr, b_busy, b_vrise, b_vhi;
  logic pv = 1'b0;
  logic [7:0] m_data, b, a;
  logic m_valid, ok, rdy, eo, ev;
  int gap;

  uart_rx_oversample #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // event counters sampled mid-cycle
  always @(negedge clk) begin
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (busy) n_busy++;
    if (rx_valid) n_vhi++;
    if (rx_valid && !pv) n_vrise++;
    if (frame_err && overrun) n_both++;
    pv = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic snap();
    b_ferr = n_ferr; b_ovr = n_ovr; b_busy = n_busy; b_vrise = n_vrise; b_vhi = n_vhi;
  endtask

  // one 8N1 frame, 16 clk per bit; rdy_at >= 0 pulses rx_ready at that clk offset
  task automatic send(input logic [7:0] d, input logic stop, input int rdy_at);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int k = 0; k < 160; k++) begin
      rx_in = f[k / 16];
      if (rdy_at >= 0) rx_ready = k == rdy_at;
      step();
    end
  endtask

  initial begin
    repeat (3) step();
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (10) step();
    // 1: single byte, consumer always ready
    rx_ready = 1'b1; snap();
    send(8'h41, 1'b1, -1);
    chk("t1_data", rx_data, 8'h41);
    chk("t1_valid", rx_valid, 0);
    chk("t1_vhi", n_vhi - b_vhi, 1);
    chk("t1_flags", (n_ferr - b_ferr) + (n_ovr - b_ovr), 0);
    chk("t1_busy", busy, 0);
    // 2: back-to-back with consumer stalled
    rx_ready = 1'b0; snap();
    send(8'h55, 1'b1, -1);
    send(8'hA3, 1'b1, -1);
    chk("t2_data", rx_data, 8'h55);
    chk("t2_valid", rx_valid, 1);
    chk("t2_ovr", n_ovr - b_ovr, 1);
    chk("t2_vrise", n_vrise - b_vrise, 1);
    rx_ready = 1'b1;
    step();
    chk("t2_drop", rx_valid, 0);
    chk("t2_keep", rx_data, 8'h55);
    // 3: stop bit low, line low for two bit times
    snap();
    send(8'h0F, 1'b0, -1);
    repeat (16) step();
    chk("t3_busy_low", busy, 1);
    chk("t3_ferr", n_ferr - b_ferr, 1);
    chk("t3_vhi", n_vhi - b_vhi, 0);
    rx_in = 1'b1;
    repeat (8) step();
    chk("t3_busy_hi", busy, 0);
    snap();
    send(8'hC3, 1'b1, -1);
    chk("t3_next", rx_data, 8'hC3);
    chk("t3_next_rise", n_vrise - b_vrise, 1);
    // 4: 5-clk glitch
    snap();
    rx_in = 1'b0;
    repeat (5) step();
    rx_in = 1'b1;
    repeat (30) step();
    chk("t4_busy_seen", n_busy != b_busy, 1);
    chk("t4_idle", busy, 0);
    chk("t4_quiet", (n_vhi - b_vhi) + (n_ferr - b_ferr) + (n_ovr - b_ovr), 0);
    // 5: reset during data bit 4, line held low after release
    for (int k = 0; k < 88; k++) begin
      rx_in = k < 16 ? 1'b0 : 1'(8'h99 >> ((k - 16) / 16));
      step();
    end
    chk("t5_busy_pre", busy, 1);
    rst_n = 1'b0; rx_in = 1'b0;
    step();
    chk("t5_data", rx_data, 0);
    chk("t5_out", {busy, rx_valid, frame_err, overrun}, 0);
    rst_n = 1'b1; snap();
    repeat (40) step();
    chk("t5_no_start", n_busy - b_busy, 0);
    rx_in = 1'b1;
    repeat (20) step();
    snap();
    send(8'h7E, 1'b1, -1);
    chk("t5_next", rx_data, 8'h7E);
    chk("t5_rise", n_vrise - b_vrise, 1);
    // 6: accept in the same cycle a new byte completes
    rx_ready = 1'b0; snap();
    a = 8'($urandom);
    b = a ^ 8'h5A;
    send(a, 1'b1, -1);
    chk("t6_first", rx_data, a);
    send(b, 1'b1, 154);
    chk("t6_data", rx_data, b);
    chk("t6_valid", rx_valid, 1);
    chk("t6_ovr", n_ovr - b_ovr, 0);
    chk("t6_rise", n_vrise - b_vrise, 1);
    rx_ready = 1'b1;
    step();
    chk("t6_drop", rx_valid, 0);
    // randomized frames against the frame-level model
    m_valid = 1'b0; m_data = b;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      ok = $urandom_range(4, 0) != 0;
      rdy = 1'($urandom_range(1, 0));
      gap = $urandom_range(20, 0) + (ok ? 0 : 16);
      rx_ready = rdy;
      if (rdy) m_valid = 1'b0;
      snap();
      send(b, ok, -1);
      eo = ok && m_valid && !rdy;
      ev = ok && !eo;
      if (ev) begin
        m_data = b;
        m_valid = !rdy;
      end
      chk("rnd_data", rx_data, m_data);
      chk("rnd_valid", rx_valid, m_valid);
      chk("rnd_ferr", n_ferr - b_ferr, !ok);
      chk("rnd_ovr", n_ovr - b_ovr, eo);
      chk("rnd_rise", n_vrise - b_vrise, ev);
      rx_in = 1'b1;
      repeat (gap) step();
    end
    chk("flag_excl", n_both, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
